// File: rtl/adventure_engine.sv
// Grid adventure game: step divider, button synchroniser, PLAY/WIN/DEAD FSM and a registered 2x16 LCD frame.
// Optional move limit enabled by defining ADVENTURE_TIMEOUT_EN.
module adventure_engine #(
    parameter int GRID_W      = 4,
    parameter int GRID_H      = 3,
    parameter int START_ROOM  = 0,
    parameter int SWORD_ROOM  = 5,
    parameter int DRAGON_ROOM = 10,
    parameter int EXIT_ROOM   = 11,
    parameter int STEP_DIV    = 20,
    parameter int MAX_MOVES   = 30,
    localparam int RW         = $clog2(GRID_W * GRID_H)
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    input  logic          N,
    input  logic          E,
    input  logic          S,
    input  logic          W,
    output logic [RW-1:0] room,
    output logic          sword,
    output logic          dragon_slain,
    output logic          win,
    output logic          dead,
    output logic [7:0]    moves,
    output logic          step_tick,
    output logic [255:0]  char_flat
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] START_X = XW'(START_ROOM % GRID_W);
    localparam logic [YW-1:0] START_Y = YW'(START_ROOM / GRID_W);

    localparam logic [63:0] TXT_ROOM    = 64'("ROOM ");
    localparam logic [63:0] TXT_PLAYING = 64'("PLAYING");
    localparam logic [63:0] TXT_WIN     = 64'("YOU WIN!");
    localparam logic [63:0] TXT_EATEN   = 64'("EATEN");
    localparam logic [63:0] TXT_TIMEOUT = 64'("TIMEOUT");

    typedef enum logic [1:0] {PLAY, WIN, DEAD} state_t;

    if (GRID_W < 2 || GRID_H < 2) begin : g_badGrid
        $error("adventure_engine: grid must be at least 2x2");
    end
    if (START_ROOM >= GRID_W * GRID_H || SWORD_ROOM >= GRID_W * GRID_H ||
        DRAGON_ROOM >= GRID_W * GRID_H || EXIT_ROOM >= GRID_W * GRID_H) begin : g_badRoom
        $error("adventure_engine: special room outside the grid");
    end
    if (STEP_DIV < 1 || MAX_MOVES < 1 || MAX_MOVES > 255) begin : g_badLimits
        $error("adventure_engine: STEP_DIV or MAX_MOVES out of range");
    end

    state_t          state_q, state_d;
    logic [XW-1:0]   xPos_q, xPos_d;
    logic [YW-1:0]   yPos_q, yPos_d;
    logic [RW-1:0]   room_q, room_d;
    logic            sword_q, sword_d;
    logic            slain_q, slain_d;
    logic [7:0]      moves_q, moves_d;
    logic            armed_q, armed_d;
    logic [STEP_DIV-1:0] div_q;
    logic [3:0]      sync1_q, sync2_q;
    logic [255:0]    frame_q;
    logic            timeoutShown;

    logic [XW-1:0]   nx;
    logic [YW-1:0]   ny;
    logic            inGrid;
    logic [RW-1:0]   nextRoom;
    logic [7:0]      movesInc;
    logic            tick;

`ifdef ADVENTURE_TIMEOUT_EN
    logic            timeout_q, timeout_d;
    assign timeoutShown = timeout_q;
`else
    assign timeoutShown = 1'b0;
`endif

    function automatic logic [255:0] putText(input logic [255:0] f, input int row,
                                             input logic [63:0] txt, input int len);
        logic [255:0] r;
        r = f;
        for (int i = 0; i < len; i++) begin
            r[(row * 16 + i) * 8 +: 8] = txt[(len - 1 - i) * 8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [255:0] buildFrame(input logic [RW-1:0] r, input logic s,
                                                input state_t st, input logic to);
        logic [255:0] f;
        f = {32{8'h20}};
        f = putText(f, 0, TXT_ROOM, 5);
        f[5 * 8 +: 8] = 8'h30 + 8'((int'(r) / 10) % 10);
        f[6 * 8 +: 8] = 8'h30 + 8'(int'(r) % 10);
        if (s) begin
            f[15 * 8 +: 8] = 8'h53;
        end
        case (st)
            WIN:     f = putText(f, 1, TXT_WIN, 8);
            DEAD:    f = to ? putText(f, 1, TXT_TIMEOUT, 7) : putText(f, 1, TXT_EATEN, 5);
            default: f = putText(f, 1, TXT_PLAYING, 7);
        endcase
        return f;
    endfunction

    assign tick     = &div_q;
    assign movesInc = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;

    // Two-flop synchroniser for {N,E,S,W} and the free-running step divider.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            div_q   <= '0;
        end else begin
            sync1_q <= {N, E, S, W};
            sync2_q <= sync1_q;
            div_q   <= div_q + STEP_DIV'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            state_q <= PLAY;
            xPos_q  <= START_X;
            yPos_q  <= START_Y;
            room_q  <= RW'(START_ROOM);
            sword_q <= 1'b0;
            slain_q <= 1'b0;
            moves_q <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            xPos_q  <= xPos_d;
            yPos_q  <= yPos_d;
            room_q  <= room_d;
            sword_q <= sword_d;
            slain_q <= slain_d;
            moves_q <= moves_d;
            armed_q <= armed_d;
        end
    end

`ifdef ADVENTURE_TIMEOUT_EN
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`endif

    // An off-grid press still counts as accepted so that the held button is disarmed.
    always_comb begin
        state_d  = state_q;
        xPos_d   = xPos_q;
        yPos_d   = yPos_q;
        room_d   = room_q;
        sword_d  = sword_q;
        slain_d  = slain_q;
        moves_d  = moves_q;
        armed_d  = armed_q;
        nx       = xPos_q;
        ny       = yPos_q;
        inGrid   = 1'b0;
        nextRoom = room_q;
`ifdef ADVENTURE_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        if (tick) begin
            if (sync2_q == 4'b0000) begin
                armed_d = 1'b1;
            end else if (armed_q && state_q == PLAY) begin
                armed_d = 1'b0;
                if (sync2_q[3]) begin
                    if (yPos_q != '0) begin
                        ny     = yPos_q - YW'(1);
                        inGrid = 1'b1;
                    end
                end else if (sync2_q[2]) begin
                    if (xPos_q != X_MAX) begin
                        nx     = xPos_q + XW'(1);
                        inGrid = 1'b1;
                    end
                end else if (sync2_q[1]) begin
                    if (yPos_q != Y_MAX) begin
                        ny     = yPos_q + YW'(1);
                        inGrid = 1'b1;
                    end
                end else begin
                    if (xPos_q != '0) begin
                        nx     = xPos_q - XW'(1);
                        inGrid = 1'b1;
                    end
                end

                if (inGrid) begin
                    nextRoom = RW'(int'(ny) * GRID_W + int'(nx));
                    xPos_d   = nx;
                    yPos_d   = ny;
                    room_d   = nextRoom;
                    moves_d  = movesInc;
                    if (nextRoom == RW'(SWORD_ROOM)) begin
                        sword_d = 1'b1;
                    end
                    if (nextRoom == RW'(DRAGON_ROOM)) begin
                        if (sword_q) begin
                            slain_d = 1'b1;
                        end else begin
                            state_d = DEAD;
                        end
                    end
                    if (nextRoom == RW'(EXIT_ROOM)) begin
                        state_d = WIN;
                    end
`ifdef ADVENTURE_TIMEOUT_EN
                    else if (state_d == PLAY && movesInc == 8'(MAX_MOVES)) begin
                        state_d   = DEAD;
                        timeout_d = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // Frame trails the game state by one cycle; reset shows room 00 regardless of START_ROOM.
    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset) begin
            frame_q <= buildFrame('0, 1'b0, PLAY, 1'b0);
        end else begin
            frame_q <= buildFrame(room_q, sword_q, state_q, timeoutShown);
        end
    end

    assign room         = room_q;
    assign sword        = sword_q;
    assign dragon_slain = slain_q;
    assign win          = (state_q == WIN);
    assign dead         = (state_q == DEAD);
    assign moves        = moves_q;
    assign step_tick    = tick;
    assign char_flat    = frame_q;

endmodule

// File: tb/tb_adventure_engine.sv
// Directed bench for adventure_engine with STEP_DIV=2; timeout scenario runs when ADVENTURE_TIMEOUT_EN is defined.
module tb_adventure_engine;

    logic         CLOCK_50 = 1'b0;
    logic         Reset;
    logic         N, E, S, W;
    logic [3:0]   room;
    logic         sword, dragon_slain, win, dead, step_tick;
    logic [7:0]   moves;
    logic [255:0] char_flat;

    int testsRun  = 0;
    int testsFail = 0;

    adventure_engine #(
        .STEP_DIV  (2),
        .MAX_MOVES (3)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .Reset        (Reset),
        .N            (N),
        .E            (E),
        .S            (S),
        .W            (W),
        .room         (room),
        .sword        (sword),
        .dragon_slain (dragon_slain),
        .win          (win),
        .dead         (dead),
        .moves        (moves),
        .step_tick    (step_tick),
        .char_flat    (char_flat)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] expFrame(input string r0, input string r1, input logic s);
        logic [255:0] f;
        f = {32{8'h20}};
        for (int i = 0; i < r0.len(); i++) f[i * 8 +: 8] = r0[i];
        for (int i = 0; i < r1.len(); i++) f[(16 + i) * 8 +: 8] = r1[i];
        if (s) f[15 * 8 +: 8] = 8'h53;
        return f;
    endfunction

    // Leaves time at #1 after the edge that consumed a step tick.
    task automatic waitTick();
        logic timedOut;
        timedOut = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge CLOCK_50);
            if (step_tick) begin
                timedOut = 1'b0;
                break;
            end
        end
        checkOutput("tickWait", timedOut, 1'b0);
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] dirMask, input int holdTicks);
        {N, E, S, W} = dirMask;
        for (int i = 0; i < holdTicks; i++) waitTick();
        {N, E, S, W} = 4'b0000;
        waitTick();
    endtask

    task automatic doReset();
        {N, E, S, W} = 4'b0000;
        @(posedge CLOCK_50);
        #3 Reset = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #3 Reset = 1'b1;
        waitTick();
    endtask

    localparam logic [3:0] DN = 4'b1000, DE = 4'b0100, DS = 4'b0010, DW = 4'b0001;

    initial begin
        Reset = 1'b1;
        {N, E, S, W} = 4'b0000;
        #2 Reset = 1'b0;
        #1;
        checkOutput("rstRoom",  room, 4'd0);
        checkOutput("rstSword", sword, 1'b0);
        checkOutput("rstSlain", dragon_slain, 1'b0);
        checkOutput("rstWin",   win, 1'b0);
        checkOutput("rstDead",  dead, 1'b0);
        checkOutput("rstMoves", moves, 8'd0);
        checkOutput("rstTick",  step_tick, 1'b0);
        checkOutput("rstFrame", char_flat, expFrame("ROOM 00", "PLAYING", 1'b0));

        // Straight to the exit
        doReset();
        applyStimulus(DE, 1);
        checkOutput("winE1", room, 4'd1);
        applyStimulus(DE, 1);
        applyStimulus(DE, 1);
        checkOutput("winE3", room, 4'd3);
        applyStimulus(DS, 1);
        checkOutput("winS1", room, 4'd7);
        checkOutput("winNotYet", win, 1'b0);
        applyStimulus(DS, 1);
        checkOutput("winRoom",  room, 4'd11);
        checkOutput("winFlag",  win, 1'b1);
        checkOutput("winMoves", moves, 8'd5);
        checkOutput("winSword", sword, 1'b0);
        checkOutput("winFrame", char_flat, expFrame("ROOM 11", "YOU WIN!", 1'b0));
        applyStimulus(DN, 1);
        checkOutput("winFrozen", room, 4'd11);

        // Walk into the dragon unarmed
        doReset();
        applyStimulus(DS, 1);
        applyStimulus(DS, 1);
        applyStimulus(DE, 1);
        checkOutput("eatPre", dead, 1'b0);
        applyStimulus(DE, 1);
        checkOutput("eatRoom",  room, 4'd10);
        checkOutput("eatDead",  dead, 1'b1);
        checkOutput("eatMoves", moves, 8'd4);
        checkOutput("eatFrame", char_flat, expFrame("ROOM 10", "EATEN", 1'b0));
        applyStimulus(DW, 1);
        applyStimulus(DN, 1);
        checkOutput("eatFrozen", room, 4'd10);
        checkOutput("eatMovesFrozen", moves, 8'd4);

        // Sword, slay, exit
        doReset();
        applyStimulus(DE, 1);
        applyStimulus(DS, 1);
        checkOutput("slaySword", sword, 1'b1);
        checkOutput("slayRoom5", room, 4'd5);
        applyStimulus(DS, 1);
        applyStimulus(DE, 1);
        checkOutput("slayFlag", dragon_slain, 1'b1);
        checkOutput("slayAlive", dead, 1'b0);
        applyStimulus(DE, 1);
        checkOutput("slayWin",   win, 1'b1);
        checkOutput("slayMoves", moves, 8'd5);
        checkOutput("slayFrame", char_flat, expFrame("ROOM 11", "YOU WIN!", 1'b1));

        // Edge bumps and a held button
        doReset();
        applyStimulus(DN, 1);
        applyStimulus(DW, 1);
        checkOutput("edgeRoom",  room, 4'd0);
        checkOutput("edgeMoves", moves, 8'd0);
        applyStimulus(DE, 4);
        checkOutput("holdRoom",  room, 4'd1);
        checkOutput("holdMoves", moves, 8'd1);

        // Priority N>E>S>W: E+S from room 1 moves east
        applyStimulus(DE | DS, 1);
        checkOutput("prioRoom", room, 4'd2);

        // Asynchronous reset mid-game
        doReset();
        applyStimulus(DE, 1);
        applyStimulus(DS, 1);
        checkOutput("arstPreSword", sword, 1'b1);
        #2 Reset = 1'b0;
        #1;
        checkOutput("arstRoom",  room, 4'd0);
        checkOutput("arstSword", sword, 1'b0);
        checkOutput("arstMoves", moves, 8'd0);
        checkOutput("arstTick",  step_tick, 1'b0);
        checkOutput("arstFrame", char_flat, expFrame("ROOM 00", "PLAYING", 1'b0));
        @(posedge CLOCK_50);
        #3 Reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("arstFrameAfter", char_flat, expFrame("ROOM 00", "PLAYING", 1'b0));
        checkOutput("arstRoomAfter",  room, 4'd0);

`ifdef ADVENTURE_TIMEOUT_EN
        doReset();
        applyStimulus(DE, 1);
        applyStimulus(DW, 1);
        checkOutput("toPre", dead, 1'b0);
        applyStimulus(DE, 1);
        checkOutput("toDead",  dead, 1'b1);
        checkOutput("toMoves", moves, 8'd3);
        checkOutput("toFrame", char_flat, expFrame("ROOM 01", "TIMEOUT", 1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
